// File: rtl/tt_sweep_ctrl_if.sv
// Bus between the sweep controller and its environment: control, the
// 3-in/2-out block-under-test drive/response pair, and the result outputs.
interface tt_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic [15:0] expected;
  logic [2:0]  dut_in;
  logic [1:0]  dut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  mismatch_mask;
  logic [15:0] captured;

  modport master (
    input  start, abort, expected, dut_out,
    output dut_in, busy, done, pass, mismatch_mask, captured
  );

  modport slave (
    output start, abort, expected, dut_out,
    input  dut_in, busy, done, pass, mismatch_mask, captured
  );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweeper: drives all 8 input combinations of a 3-in/2-out block,
// lets each settle, samples the response and compares it to a latched table.
module tt_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input logic            clk,
  input logic            rst_n,
  tt_sweep_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

  state_t      state, state_nxt;
  logic [2:0]  row, row_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [15:0] exp_q, exp_nxt;
  logic [15:0] cap, cap_nxt;
  logic [7:0]  mask, mask_nxt;
  logic        pass_q, pass_nxt;
  logic [2:0]  din, din_nxt;
  logic [3:0]  bit_idx;

  assign bit_idx = {row, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      row    <= 3'd0;
      cnt    <= 8'd0;
      exp_q  <= 16'h0000;
      cap    <= 16'h0000;
      mask   <= 8'h00;
      pass_q <= 1'b0;
      din    <= 3'd0;
    end else begin
      state  <= state_nxt;
      row    <= row_nxt;
      cnt    <= cnt_nxt;
      exp_q  <= exp_nxt;
      cap    <= cap_nxt;
      mask   <= mask_nxt;
      pass_q <= pass_nxt;
      din    <= din_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    cnt_nxt   = cnt;
    exp_nxt   = exp_q;
    cap_nxt   = cap;
    mask_nxt  = mask;
    pass_nxt  = pass_q;
    din_nxt   = din;

    case (state)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          exp_nxt   = bus.expected;
          cap_nxt   = 16'h0000;
          mask_nxt  = 8'h00;
          pass_nxt  = 1'b0;
          row_nxt   = 3'd0;
          din_nxt   = 3'd0;
          cnt_nxt   = SETTLE_LOAD;
          state_nxt = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (bus.abort) begin
          din_nxt   = 3'd0;
          state_nxt = ST_IDLE;
        end else if (cnt == 8'd0) begin
          state_nxt = ST_SAMPLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end

      ST_SAMPLE: begin
        if (bus.abort) begin
          din_nxt   = 3'd0;
          state_nxt = ST_IDLE;
        end else begin
          cap_nxt[bit_idx +: 2] = bus.dut_out;
          if (bus.dut_out != exp_q[bit_idx +: 2]) begin
            mask_nxt[row] = 1'b1;
          end
          // pass is settled on entry to DONE so it is valid alongside done
          if (row == 3'd7) begin
            pass_nxt  = (mask_nxt == 8'h00);
            state_nxt = ST_DONE;
          end else begin
            row_nxt   = row + 3'd1;
            din_nxt   = row + 3'd1;
            cnt_nxt   = SETTLE_LOAD;
            state_nxt = ST_SETTLE;
          end
        end
      end

      ST_DONE: begin
        din_nxt   = 3'd0;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.dut_in        = din;
  assign bus.busy          = (state != ST_IDLE);
  assign bus.done          = (state == ST_DONE);
  assign bus.pass          = pass_q;
  assign bus.mismatch_mask = mask;
  assign bus.captured      = cap;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench for tt_sweep_ctrl: directed sweeps on a SETTLE=2 and a
// SETTLE=1 instance, results checked by done-triggered monitors.
module tb_tt_sweep_ctrl;

  typedef struct {
    int          lat;
    logic        pass;
    logic [7:0]  mask;
    logic [15:0] cap;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   start2, start1;
  int   vectors;
  int   miscompares;

  logic [15:0] tbl2, tbl1;
  logic        fault2;

  exp_t sb2[$];
  exp_t sb1[$];

  tt_sweep_ctrl_if bus2 ();
  tt_sweep_ctrl_if bus1 ();

  tt_sweep_ctrl #(.SETTLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  tt_sweep_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model of the block under test: a plain truth-table lookup, optional row 3 fault
  always_comb begin
    bus2.dut_out = tbl2[{bus2.dut_in, 1'b0} +: 2];
    if (fault2 && bus2.dut_in == 3'd3) bus2.dut_out = 2'b11;
  end

  always_comb begin
    bus1.dut_out = tbl1[{bus1.dut_in, 1'b0} +: 2];
  end

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor2
    exp_t e;
    if (bus2.done === 1'b1) begin
      if (sb2.size() == 0) begin
        check_output("spurious_done2", 32'(bus2.done), 32'd0);
      end else begin
        e = sb2.pop_front();
        check_output("latency2", 32'(cyc - start2 + 1), 32'(e.lat));
        check_output("pass2", 32'(bus2.pass), 32'(e.pass));
        check_output("mask2", 32'(bus2.mismatch_mask), 32'(e.mask));
        check_output("captured2", 32'(bus2.captured), 32'(e.cap));
      end
    end
  end

  always @(negedge clk) begin : monitor1
    exp_t e;
    if (bus1.done === 1'b1) begin
      if (sb1.size() == 0) begin
        check_output("spurious_done1", 32'(bus1.done), 32'd0);
      end else begin
        e = sb1.pop_front();
        check_output("latency1", 32'(cyc - start1 + 1), 32'(e.lat));
        check_output("pass1", 32'(bus1.pass), 32'(e.pass));
        check_output("mask1", 32'(bus1.mismatch_mask), 32'(e.mask));
        check_output("captured1", 32'(bus1.captured), 32'(e.cap));
      end
    end
  end

  task automatic push2(int lat, logic pass, logic [7:0] mask, logic [15:0] cap);
    exp_t e;
    e.lat = lat; e.pass = pass; e.mask = mask; e.cap = cap;
    sb2.push_back(e);
  endtask

  task automatic apply_stimulus2();
    @(negedge clk) bus2.start = 1'b1;
    @(negedge clk) bus2.start = 1'b0;
    start2 = cyc;
  endtask

  task automatic goto2(int n);
    while (cyc - start2 + 1 < n) @(negedge clk);
  endtask

  task automatic drain2();
    int n = 0;
    while (sb2.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb2.size() != 0) begin
      check_output("timeout2", 32'(sb2.size()), 32'd0);
      sb2.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_state2(string tag, logic busy, logic pass, logic [7:0] mask, logic [15:0] cap);
    check_output({tag, "_busy"}, 32'(bus2.busy), 32'(busy));
    check_output({tag, "_done"}, 32'(bus2.done), 32'd0);
    check_output({tag, "_pass"}, 32'(bus2.pass), 32'(pass));
    check_output({tag, "_mask"}, 32'(bus2.mismatch_mask), 32'(mask));
    check_output({tag, "_captured"}, 32'(bus2.captured), 32'(cap));
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    exp_t e1;
    int   n;
    vectors = 0; miscompares = 0; cyc = 0; start2 = 0; start1 = 0;
    tbl2 = 16'hFF7E; tbl1 = 16'hA5C3; fault2 = 1'b0;
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.expected = 16'h0000;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.expected = 16'h0000;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state of both instances
    repeat (2) @(negedge clk);
    check_state2("reset", 1'b0, 1'b0, 8'h00, 16'h0000);
    check_output("reset_dut_in2", 32'(bus2.dut_in), 32'd0);
    check_output("reset_busy1", 32'(bus1.busy), 32'd0);
    check_output("reset_dut_in1", 32'(bus1.dut_in), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output("post_reset_idle2", 32'(bus2.busy), 32'd0);

    // Matching block; expected input changed mid-sweep must not matter
    bus2.expected = 16'hFF7E;
    push2(25, 1'b1, 8'h00, 16'hFF7E);
    apply_stimulus2();
    goto2(10);
    bus2.expected = 16'h0000;
    drain2();
    check_state2("after_match", 1'b0, 1'b1, 8'h00, 16'hFF7E);

    // Row 3 forced to 2'b11
    bus2.expected = 16'hFF7E;
    fault2 = 1'b1;
    push2(25, 1'b0, 8'h08, 16'hFFFE);
    apply_stimulus2();
    drain2();
    fault2 = 1'b0;
    check_state2("after_fault", 1'b0, 1'b0, 8'h08, 16'hFFFE);

    // start re-pulsed while busy at cycles 5 and 20; abort held during DONE
    push2(25, 1'b1, 8'h00, 16'hFF7E);
    apply_stimulus2();
    goto2(5);
    bus2.start = 1'b1;
    @(negedge clk) bus2.start = 1'b0;
    goto2(20);
    bus2.start = 1'b1;
    @(negedge clk) bus2.start = 1'b0;
    goto2(25);
    check_output("done_at_25", 32'(bus2.done), 32'd1);
    bus2.abort = 1'b1;
    @(negedge clk) bus2.abort = 1'b0;
    drain2();
    repeat (30) @(negedge clk);
    check_state2("after_restart_try", 1'b0, 1'b1, 8'h00, 16'hFF7E);

    // Abort during row 4 settle keeps partial results, no done
    apply_stimulus2();
    goto2(13);
    bus2.abort = 1'b1;
    @(negedge clk) bus2.abort = 1'b0;
    check_state2("abort", 1'b0, 1'b0, 8'h00, 16'h007E);
    repeat (30) @(negedge clk);
    check_state2("abort_later", 1'b0, 1'b0, 8'h00, 16'h007E);

    // Asynchronous reset during row 6 clears everything at once
    push2(25, 1'b1, 8'h00, 16'hFF7E);
    apply_stimulus2();
    drain2();
    apply_stimulus2();
    goto2(19);
    check_output("pre_reset_busy", 32'(bus2.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_state2("mid_reset", 1'b0, 1'b0, 8'h00, 16'h0000);
    check_output("mid_reset_dut_in", 32'(bus2.dut_in), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("post_reset_no_start", 32'(bus2.busy), 32'd0);
    push2(25, 1'b1, 8'h00, 16'hFF7E);
    apply_stimulus2();
    drain2();
    check_state2("after_reset_sweep", 1'b0, 1'b1, 8'h00, 16'hFF7E);

    // SETTLE=1: start+abort together is ignored, then a clean sweep
    bus1.expected = 16'hA5C3;
    @(negedge clk) begin bus1.start = 1'b1; bus1.abort = 1'b1; end
    @(negedge clk) begin bus1.start = 1'b0; bus1.abort = 1'b0; end
    check_output("start_abort_idle1", 32'(bus1.busy), 32'd0);
    repeat (3) @(negedge clk);
    check_output("start_abort_still_idle1", 32'(bus1.busy), 32'd0);
    e1.lat = 17; e1.pass = 1'b1; e1.mask = 8'h00; e1.cap = 16'hA5C3;
    sb1.push_back(e1);
    @(negedge clk) bus1.start = 1'b1;
    @(negedge clk) bus1.start = 1'b0;
    start1 = cyc;
    for (int k = 1; k <= 17; k++) begin
      check_output($sformatf("dut_in1_cycle%0d", k), 32'(bus1.dut_in),
                   (k <= 16) ? 32'((k - 1) / 2) : 32'd7);
      if (k < 17) @(negedge clk);
    end
    n = 0;
    while (sb1.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb1.size() != 0) begin
      check_output("timeout1", 32'(sb1.size()), 32'd0);
      sb1.delete();
    end
    repeat (3) @(negedge clk);
    check_output("final_idle1", 32'(bus1.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 2, giving the number of settle cycles per row before sampling; the legal range is 1..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: begin a sweep; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1 bit: synchronous cancel of a running sweep.
REQ-006 SHALL have port expected, input, 16 bits: expected table; row i occupies bits [2i+1:2i], ordered {out1,out2}.
REQ-007 SHALL have port dut_in, output, 3 bits: drives the 3-input/2-output block under test as {in3,in2,in1}.
REQ-008 SHALL have port dut_out, input, 2 bits: response of the block under test, ordered {out1,out2}.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-011 SHALL have port pass, output, 1 bit: the last completed sweep had zero mismatches.
REQ-012 SHALL have port mismatch_mask, output, 8 bits: bit i set when row i differed from its expected value.
REQ-013 SHALL have port captured, output, 16 bits: the sampled dut_out per row, in the same layout as expected.

Function
REQ-014 SHALL implement the states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 IDLE with start=1 and abort=0 at an edge: SHALL latch expected, clear mismatch_mask, captured and pass, set row=0, drive dut_in=0, load settle counter with SETTLE-1, and enter SETTLE.
REQ-016 SETTLE: SHALL decrement the counter each cycle; when the counter reads 0, it SHALL enter SAMPLE, so the state lasts exactly SETTLE cycles.
REQ-017 SAMPLE: SHALL write dut_out into captured[2row+1:2row] and set mismatch_mask[row] if dut_out differs from the latched expected value for that row.
REQ-018 SAMPLE with row<7: SHALL increment row, drive dut_in=row+1, reload the counter with SETTLE-1, and enter SETTLE.
REQ-019 SAMPLE with row=7: SHALL enter DONE; dut_in SHALL hold 7.
REQ-020 DONE: SHALL assert done for exactly one cycle, set pass=1 if and only if the final mismatch_mask is 0, return dut_in to 0, and enter IDLE.
REQ-021 Each row SHALL take SETTLE+1 cycles.
REQ-022 done SHALL be high in the cycle 8*(SETTLE+1)+1 cycles after the start edge (25 cycles for SETTLE=2).
REQ-023 start asserted while busy=1 SHALL be ignored, with no restart and no effect on results.
REQ-024 abort=1 in SETTLE or SAMPLE: SHALL go to IDLE on that edge with no capture that cycle and no done pulse; pass SHALL stay 0 and partial captured/mismatch_mask SHALL be retained.
REQ-025 abort=1 in DONE: SHALL be ignored, and the sweep completes normally.
REQ-026 start and abort high together in IDLE: abort SHALL win and the block SHALL stay in IDLE.
REQ-027 The expected input SHALL be used only through its latched copy, so changes to expected mid-sweep have no effect.
REQ-028 The row counter SHALL be 3 bits and SHALL never wrap inside a sweep.
REQ-029 The settle counter SHALL be 8 bits.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE.
REQ-031 rst_n=0 SHALL immediately force dut_in=0, busy=0, done=0, pass=0, mismatch_mask=0, captured=0, row=0 and settle counter=0.
REQ-032 Reset asserted mid-sweep SHALL discard all progress.
REQ-033 After rst_n rises, the first sweep SHALL begin only on a later start.

Verification
REQ-034 SETTLE=2, expected=16'hFF7E, model block matches -> done pulses 25 cycles after start, pass=1, mismatch_mask=8'h00, captured=16'hFF7E.
REQ-035 Same setup, model forces row 3 to 2'b11 -> pass=0, mismatch_mask=8'h08, captured=16'hFFFE.
REQ-036 abort asserted during row 4 SETTLE -> busy=0 next cycle, no done pulse, captured[7:0]=8'h7E, mismatch_mask=8'h00, pass=0.
REQ-037 start pulsed again at cycles 5 and 20 of a sweep -> no effect; exactly one done pulse at cycle 25.
REQ-038 rst_n pulled low during row 6 -> all outputs 0 at once; a new start gives a full, correct 25-cycle sweep.
REQ-039 SETTLE=1 with start and abort high together in IDLE -> stays in IDLE; a later start alone gives done after 17 cycles, and dut_in steps 0..7, holding each value for 2 cycles.
